// File: rtl/switch_debouncer_pkg.sv
// Shared constants and helpers for the switch debouncer.
package switch_debouncer_pkg;

    localparam int unsigned DEFAULT_WIDTH         = 2;
    localparam int unsigned DEFAULT_STABLE_CYCLES = 4;

    function automatic int unsigned cnt_width(input int unsigned stable_cycles);
        return $clog2(stable_cycles);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: two-flop synchronizer, persistence counter, level and edge strobes.
module debounce_channel
    import switch_debouncer_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned     CW       = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          level_next;
    logic          rise_next;
    logic          fall_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Any cycle where sync2 matches level clears the count, so glitches never accumulate.
    always_comb begin
        cnt_next   = '0;
        level_next = level;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        if (sync2 != level) begin
            if (cnt == CNT_LAST) begin
                level_next = sync2;
                rise_next  = sync2;
                fall_next  = ~sync2;
            end else begin
                cnt_next = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            level <= level_next;
            rise  <= rise_next;
            fall  <= fall_next;
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// Multi-channel switch debouncer; each bit is an independent debounce_channel.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int unsigned WIDTH         = DEFAULT_WIDTH,
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic             input_clock1_1,
    input  logic             input_reset_n_2,
    input  logic [WIDTH-1:0] input_switch_3,
    output logic [WIDTH-1:0] output_level_4,
    output logic [WIDTH-1:0] output_rise_5,
    output logic [WIDTH-1:0] output_fall_6
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_ch (
            .clk   (input_clock1_1),
            .rst_n (input_reset_n_2),
            .raw   (input_switch_3[i]),
            .level (output_level_4[i]),
            .rise  (output_rise_5[i]),
            .fall  (output_fall_6[i])
        );
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench: stimulus queues expected strobes, a negedge monitor pops and checks them.
module tb_switch_debouncer;

    localparam int LAT = 6;  // STABLE_CYCLES + 2 edges from raw change to strobe

    logic       clk;
    logic       rst_n;
    logic [1:0] sw;
    logic [1:0] level;
    logic [1:0] rise;
    logic [1:0] fall;

    typedef struct {
        int cyc;
        int ch;
        bit is_rise;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   n_vec;
    int   n_err;

    switch_debouncer #(
        .WIDTH        (2),
        .STABLE_CYCLES(4)
    ) dut (
        .input_clock1_1 (clk),
        .input_reset_n_2(rst_n),
        .input_switch_3 (sw),
        .output_level_4 (level),
        .output_rise_5  (rise),
        .output_fall_6  (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input bit r);
        exp_t e;
        e.cyc     = cyc + LAT;
        e.ch      = ch;
        e.is_rise = r;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < 2; c++) begin
                if (rise[c] || fall[c]) begin
                    if (q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL spurious_strobe: ch%0d rise=%b fall=%b at cyc %0d, required no strobe",
                                 c, rise[c], fall[c], cyc);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("strobe_cycle", cyc, e.cyc);
                        chk("strobe_channel", c, e.ch);
                        chk("strobe_rise", int'(rise[c]), int'(e.is_rise));
                        chk("strobe_fall", int'(fall[c]), int'(!e.is_rise));
                        chk("strobe_level", int'(level[c]), int'(e.is_rise));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        sw    = 2'b11;
        tick(3);
        chk("reset_level", int'(level), 0);
        chk("reset_rise", int'(rise), 0);
        chk("reset_fall", int'(fall), 0);

        rst_n = 1'b1;
        push(0, 1'b1);
        push(1, 1'b1);
        tick(10);
        chk("post_reset_level", int'(level), 3);
        tick(5);
        chk("post_reset_level_held", int'(level), 3);

        sw = 2'b10; push(0, 1'b0); tick(10);
        chk("step_fall_level", int'(level), 2);
        sw = 2'b11; push(0, 1'b1); tick(10);
        chk("step_rise_level", int'(level), 3);

        sw = 2'b01; push(1, 1'b0); tick(10);
        chk("ch1_low_level", int'(level), 1);
        sw[1] = 1'b1; tick(3);
        sw[1] = 1'b0; tick(3);
        sw[1] = 1'b1; tick(3);
        sw[1] = 1'b0; tick(3);
        chk("bounce_level_unchanged", int'(level), 1);
        sw[1] = 1'b1; push(1, 1'b1); tick(10);
        chk("bounce_final_level", int'(level), 3);

        sw = 2'b10; push(0, 1'b0); tick(10);
        chk("pre_pulse_level", int'(level), 2);
        sw[0] = 1'b1; tick(3);
        sw[0] = 1'b0; tick(10);
        chk("pulse3_suppressed", int'(level), 2);
        sw[0] = 1'b1; push(0, 1'b1); tick(4);
        sw[0] = 1'b0; push(0, 1'b0); tick(10);
        chk("pulse4_returned_low", int'(level), 2);

        sw = 2'b00; push(1, 1'b0); tick(10);
        chk("both_low_level", int'(level), 0);
        sw = 2'b01; push(0, 1'b1); tick(2);
        sw = 2'b11; push(1, 1'b1); tick(10);
        chk("independent_level", int'(level), 3);

        sw = 2'b00; tick(4);
        rst_n = 1'b0;
        #1;
        chk("async_reset_level", int'(level), 0);
        chk("async_reset_rise", int'(rise), 0);
        chk("async_reset_fall", int'(fall), 0);
        tick(3);
        rst_n = 1'b1;
        tick(15);
        chk("after_reset_level", int'(level), 0);
        chk("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
